life_gen_engine: RTL and testbench

- Downstream consumer of the slow flush clock.
- Holds the Life cell grid and computes one new generation per flush rising edge while running.
- Applies user commands from usr_op: run/pause, single step, clear, cursor moves and cell toggle.
- Presents the current generation as a flat, stable vector to the display stage.

---
 rtl/life_gen_engine.sv | 164 ++++++++++++++++
 tb/tb_life_gen_engine.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_gen_engine.sv
// Conway's Life engine: holds the cell grid, computes one generation row-by-row into a
// shadow buffer on flush ticks or step commands, and applies cursor/edit commands.
module life_gen_engine #(
  parameter int unsigned ROWS  = 16,
  parameter int unsigned COLS  = 16,
  parameter int unsigned WRAP  = 1,
  parameter int unsigned GEN_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_in,
  input  logic [3:0]               usr_op,
  output logic [ROWS*COLS-1:0]     grid,
  output logic [$clog2(ROWS)-1:0]  cur_row,
  output logic [$clog2(COLS)-1:0]  cur_col,
  output logic                     running,
  output logic                     busy,
  output logic [GEN_W-1:0]         gen_count
);

  localparam int unsigned N  = ROWS * COLS;
  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned IW = $clog2(N);

  localparam logic [3:0] OP_RUN    = 4'd1;
  localparam logic [3:0] OP_STEP   = 4'd2;
  localparam logic [3:0] OP_CLEAR  = 4'd3;
  localparam logic [3:0] OP_TOGGLE = 4'd4;
  localparam logic [3:0] OP_UP     = 4'd5;
  localparam logic [3:0] OP_DOWN   = 4'd6;
  localparam logic [3:0] OP_LEFT   = 4'd7;
  localparam logic [3:0] OP_RIGHT  = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_COMMIT} state_t;

  state_t          r_state;
  logic [RW-1:0]   r_row_idx;
  logic [N-1:0]    r_shadow;
  logic            r_f1;
  logic            r_f2;
  logic [3:0]      r_op_q;

  logic            w_tick;
  logic            w_press;
  logic            w_start;
  logic [IW-1:0]   w_cur_idx;
  logic [RW-1:0]   w_up_idx;
  logic [RW-1:0]   w_dn_idx;
  logic            w_up_ok;
  logic            w_dn_ok;
  logic [COLS-1:0] w_up;
  logic [COLS-1:0] w_mid;
  logic [COLS-1:0] w_dn;
  logic [COLS-1:0] w_next_row;

  assign w_tick    = r_f1 & ~r_f2;
  assign w_press   = (usr_op != 4'd0) && (r_op_q == 4'd0);
  assign w_start   = (w_tick && running) || (w_press && (usr_op == OP_STEP) && !running);
  assign w_cur_idx = IW'(32'(cur_row) * COLS + 32'(cur_col));

  // Life rule for one row given the rows above/below (already zeroed when off-grid)
  function automatic logic [COLS-1:0] row_next(input logic [COLS-1:0] up,
                                               input logic [COLS-1:0] mid,
                                               input logic [COLS-1:0] dn);
    logic [COLS-1:0] res;
    logic [3:0]      n;
    int              l;
    int              r;
    res = '0;
    for (int c = 0; c < int'(COLS); c++) begin
      l = (c == 0) ? int'(COLS) - 1 : c - 1;
      r = (c == int'(COLS) - 1) ? 0 : c + 1;
      n = 4'(up[c]) + 4'(dn[c]);
      if (c != 0 || WRAP != 0)
        n = n + 4'(up[l]) + 4'(mid[l]) + 4'(dn[l]);
      if (c != int'(COLS) - 1 || WRAP != 0)
        n = n + 4'(up[r]) + 4'(mid[r]) + 4'(dn[r]);
      res[c] = (n == 4'd3) || (mid[c] && (n == 4'd2));
    end
    return res;
  endfunction

  // Neighbouring rows of the row being computed, with edge handling
  always_comb begin
    w_up_ok  = 1'b1;
    w_dn_ok  = 1'b1;
    w_up_idx = r_row_idx - 1'b1;
    w_dn_idx = r_row_idx + 1'b1;
    if (r_row_idx == '0) begin
      w_up_idx = RW'(ROWS - 1);
      w_up_ok  = (WRAP != 0);
    end
    if (r_row_idx == RW'(ROWS - 1)) begin
      w_dn_idx = '0;
      w_dn_ok  = (WRAP != 0);
    end
    w_mid      = grid[32'(r_row_idx) * COLS +: COLS];
    w_up       = w_up_ok ? grid[32'(w_up_idx) * COLS +: COLS] : '0;
    w_dn       = w_dn_ok ? grid[32'(w_dn_idx) * COLS +: COLS] : '0;
    w_next_row = row_next(w_up, w_mid, w_dn);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_row_idx <= '0;
      r_shadow  <= '0;
      r_f1      <= 1'b0;
      r_f2      <= 1'b0;
      r_op_q    <= 4'd0;
      grid      <= '0;
      cur_row   <= '0;
      cur_col   <= '0;
      running   <= 1'b0;
      busy      <= 1'b0;
      gen_count <= '0;
    end else begin
      r_f1   <= flush_in;
      r_f2   <= r_f1;
      r_op_q <= usr_op;

      // Commands honoured in every state
      if (w_press) begin
        case (usr_op)
          OP_RUN:   running <= ~running;
          OP_UP:    cur_row <= (cur_row == '0) ? RW'(ROWS - 1) : cur_row - 1'b1;
          OP_DOWN:  cur_row <= (cur_row == RW'(ROWS - 1)) ? '0 : cur_row + 1'b1;
          OP_LEFT:  cur_col <= (cur_col == '0) ? CW'(COLS - 1) : cur_col - 1'b1;
          OP_RIGHT: cur_col <= (cur_col == CW'(COLS - 1)) ? '0 : cur_col + 1'b1;
          default:  ;
        endcase
      end

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state   <= S_COMPUTE;
            r_row_idx <= '0;
            busy      <= 1'b1;
          end else if (w_press && usr_op == OP_CLEAR) begin
            grid      <= '0;
            gen_count <= '0;
          end else if (w_press && usr_op == OP_TOGGLE) begin
            grid[w_cur_idx] <= ~grid[w_cur_idx];
          end
        end
        S_COMPUTE: begin
          r_shadow[32'(r_row_idx) * COLS +: COLS] <= w_next_row;
          if (r_row_idx == RW'(ROWS - 1)) r_state <= S_COMMIT;
          else                            r_row_idx <= r_row_idx + 1'b1;
        end
        S_COMMIT: begin
          grid      <= r_shadow;
          gen_count <= gen_count + GEN_W'(1);
          busy      <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_life_gen_engine.sv
// Bench for life_gen_engine: directed command/flush stimulus, commit scoreboard fed by a
// reference Life model, plus hand-computed pattern checks.
module tb_life_gen_engine;

  localparam int R = 16;
  localparam int C = 16;
  localparam int N = R * C;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush_in;
  logic [3:0]   usr_op;
  logic [N-1:0] grid, grid0;
  logic [3:0]   cur_row, cur_col, cur_row0, cur_col0;
  logic         running, busy, running0, busy0;
  logic [15:0]  gen_count, gen_count0;

  life_gen_engine #(.ROWS(R), .COLS(C), .WRAP(1), .GEN_W(16)) u_dut (
    .clk(clk), .rst(rst), .flush_in(flush_in), .usr_op(usr_op),
    .grid(grid), .cur_row(cur_row), .cur_col(cur_col),
    .running(running), .busy(busy), .gen_count(gen_count));

  life_gen_engine #(.ROWS(R), .COLS(C), .WRAP(0), .GEN_W(16)) u_dut_nowrap (
    .clk(clk), .rst(rst), .flush_in(flush_in), .usr_op(usr_op),
    .grid(grid0), .cur_row(cur_row0), .cur_col(cur_col0),
    .running(running0), .busy(busy0), .gen_count(gen_count0));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [N-1:0] exp_grid_q[$];
  logic [15:0]  exp_gen_q[$];

  logic [N-1:0] m_grid;
  logic [15:0]  m_gen;
  int           m_row;
  int           m_col;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic int bp(input int r, input int c);
    return r * C + c;
  endfunction

  // Reference: whole-grid Life step
  function automatic logic [N-1:0] life(input logic [N-1:0] g, input bit wrap);
    logic [N-1:0] o;
    int n, rr, cc;
    o = '0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr == 0 && dc == 0) continue;
            rr = r + dr;
            cc = c + dc;
            if (wrap) begin
              rr = (rr + R) % R;
              cc = (cc + C) % C;
            end else if (rr < 0 || rr >= R || cc < 0 || cc >= C) continue;
            n += int'(g[bp(rr, cc)]);
          end
        o[bp(r, c)] = (n == 3) || (g[bp(r, c)] && n == 2);
      end
    return o;
  endfunction

  // Commit monitor: every falling busy outside reset is one committed generation
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    if (!rst && prev_busy && !busy) begin
      if (exp_grid_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_commit actual_gen=%0d required=none", gen_count);
      end else begin
        logic [N-1:0] eg;
        logic [15:0]  en;
        eg = exp_grid_q.pop_front();
        en = exp_gen_q.pop_front();
        check("commit_grid", grid, eg);
        check("commit_gen", N'(gen_count), N'(en));
      end
    end
    prev_busy = busy;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] op);
    usr_op = op;
    cyc(2);
    usr_op = 4'd0;
    cyc(2);
  endtask

  task automatic expect_gen();
    m_grid = life(m_grid, 1'b1);
    m_gen  = m_gen + 16'd1;
    exp_grid_q.push_back(m_grid);
    exp_gen_q.push_back(m_gen);
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (k == 100) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout actual=busy required=idle", name);
    end
    cyc(1);
  endtask

  task automatic set_cell(input int r, input int c);
    while (m_row != r) begin press(4'd6); m_row = (m_row + 1) % R; end
    while (m_col != c) begin press(4'd8); m_col = (m_col + 1) % C; end
    press(4'd4);
    m_grid[bp(r, c)] = ~m_grid[bp(r, c)];
  endtask

  task automatic step();
    expect_gen();
    press(4'd2);
    wait_idle("step");
  endtask

  logic [N-1:0] e;
  logic [N-1:0] glider0;
  logic [N-1:0] old;
  int           lat;

  initial begin
    rst = 1'b1; flush_in = 1'b0; usr_op = 4'd0;
    m_grid = '0; m_gen = 16'd0; m_row = 0; m_col = 0;
    cyc(3);
    rst = 1'b0;
    cyc(1);
    check("reset_grid", grid, '0);
    check("reset_gen", N'(gen_count), '0);
    check("reset_cursor", N'({cur_row, cur_col}), '0);
    check("reset_run_busy", N'({running, busy}), '0);

    // Cursor: long hold gives one move, up from row 0 wraps, toggle twice
    usr_op = 4'd6; cyc(100); usr_op = 4'd0; cyc(2);
    check("hold_down_once", N'(cur_row), N'(1));
    press(4'd5); press(4'd5);
    check("up_wrap", N'(cur_row), N'(R - 1));
    m_row = R - 1;
    press(4'd4);
    e = '0; e[bp(15, 0)] = 1'b1;
    check("toggle_on", grid, e);
    press(4'd4);
    check("toggle_off", grid, '0);

    // Blinker under run mode, with latency measurement
    press(4'd1);
    check("running_on", N'(running), N'(1));
    set_cell(7, 6); set_cell(7, 7); set_cell(7, 8);
    e = '0; e[bp(7, 6)] = 1'b1; e[bp(7, 7)] = 1'b1; e[bp(7, 8)] = 1'b1;
    check("blinker_setup", grid, e);
    cyc(2);
    expect_gen();
    old = grid;
    lat = 0;
    flush_in = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      cyc(1);
      if (k == 3) flush_in = 1'b0;
      if (k == 10) begin
        check("busy_mid", N'(busy), N'(1));
        check("grid_stable_mid", grid, old);
      end
      if (grid != old) begin lat = k; break; end
    end
    check("latency", N'(lat), N'(R + 3));
    cyc(2);
    e = '0; e[bp(6, 7)] = 1'b1; e[bp(7, 7)] = 1'b1; e[bp(8, 7)] = 1'b1;
    check("blinker_vert", grid, e);
    check("blinker_gen1", N'(gen_count), N'(1));
    expect_gen();
    flush_in = 1'b1; cyc(3); flush_in = 1'b0;
    wait_idle("blink2");
    e = '0; e[bp(7, 6)] = 1'b1; e[bp(7, 7)] = 1'b1; e[bp(7, 8)] = 1'b1;
    check("blinker_horiz", grid, e);
    check("blinker_gen2", N'(gen_count), N'(2));

    // Flush period shorter than a generation: every other rising edge lands while busy
    for (int i = 0; i < 5; i++) expect_gen();
    for (int i = 0; i < 10; i++) begin
      flush_in = 1'b1; cyc(5);
      flush_in = 1'b0; cyc(5);
    end
    wait_idle("fast");
    check("fast_gen", N'(gen_count), N'(7));
    check("fast_queue_empty", N'(exp_grid_q.size()), '0);

    press(4'd3);
    m_grid = '0; m_gen = 16'd0;
    check("clear_grid", grid, '0);
    check("clear_gen", N'(gen_count), '0);

    // Step ignored while running
    press(4'd2); cyc(25);
    check("step_while_run", N'({busy, gen_count}), '0);
    press(4'd1);
    check("paused", N'(running), '0);

    // Glider on the torus
    set_cell(0, 1); set_cell(1, 2); set_cell(2, 0); set_cell(2, 1); set_cell(2, 2);
    glider0 = m_grid;
    for (int i = 0; i < 4; i++) step();
    e = '0;
    e[bp(1, 2)] = 1'b1; e[bp(2, 3)] = 1'b1;
    e[bp(3, 1)] = 1'b1; e[bp(3, 2)] = 1'b1; e[bp(3, 3)] = 1'b1;
    check("glider_shift", grid, e);
    for (int i = 0; i < 4 * R - 4; i++) step();
    check("glider_return", grid, glider0);
    check("glider_gen", N'(gen_count), N'(64));

    // Corner block plus opposite corner cell, both edge modes
    press(4'd3);
    m_grid = '0; m_gen = 16'd0;
    set_cell(0, 0); set_cell(0, 1); set_cell(1, 0); set_cell(1, 1); set_cell(15, 15);
    step();
    e = '0;
    e[bp(0, 1)] = 1'b1; e[bp(1, 0)] = 1'b1; e[bp(1, 1)] = 1'b1;
    e[bp(15, 0)] = 1'b1; e[bp(0, 15)] = 1'b1;
    check("corner_wrap", grid, e);
    e = '0;
    e[bp(0, 0)] = 1'b1; e[bp(0, 1)] = 1'b1; e[bp(1, 0)] = 1'b1; e[bp(1, 1)] = 1'b1;
    check("corner_nowrap", grid0, e);
    check("corner_nowrap_gen", N'(gen_count0), N'(1));

    // Reset in the middle of a computation
    press(4'd1);
    flush_in = 1'b1;
    cyc(6);
    rst = 1'b1;
    cyc(1);
    @(negedge clk);
    check("rst_mid_busy", N'(busy), '0);
    check("rst_mid_grid", grid, '0);
    check("rst_mid_gen", N'(gen_count), '0);
    check("rst_mid_run", N'(running), '0);
    cyc(1);
    rst = 1'b0;
    flush_in = 1'b0; cyc(5);
    flush_in = 1'b1; cyc(5);
    flush_in = 1'b0; cyc(30);
    check("paused_flush_grid", grid, '0);
    check("paused_flush_gen", N'({busy, gen_count}), '0);

    cyc(5);
    check("final_queue_empty", N'(exp_grid_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
